// File: rtl/mem_access_pkg.sv
// Shared types and funct3 encodings for the memory-stage load/store unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'b00,
        FaultMisalign = 2'b01,
        FaultUnsup    = 2'b10,
        FaultTimeout  = 2'b11
    } fault_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication and enables, load shift and extension.
module lsu_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    // Size bits only, so loads get the same lane enables as stores of equal width.
    always_comb begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_be_o    = 4'b0001 << st_off_i;
            end
            2'b01: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_be_o    = 4'b0011 << st_off_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = shifted;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data_o = {24'h0, shifted[7:0]};
            F3_HU:   ld_data_o = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes the MEM-stage op, drives a registered
// req/ready bus through an IDLE/REQ/DONE FSM and returns extended load data.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic [1:0]  FaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CntW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        op_valid, ld_ok, st_ok, unsup, misal;
    fault_e      req_fault, fault;
    logic [31:0] al_wdata, al_ld;
    logic [3:0]  al_be;

    lsu_lane_align u_align (
        .st_funct3_i (funct3M),
        .st_off_i    (ALUResultM[1:0]),
        .st_data_i   (WriteDataM),
        .st_wdata_o  (al_wdata),
        .st_be_o     (al_be),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (mem_rdata),
        .ld_data_o   (al_ld)
    );

    always_comb begin
        op_valid = MemReadM | MemWriteM;
        ld_ok    = (funct3M == F3_B) || (funct3M == F3_H) || (funct3M == F3_W) ||
                   (funct3M == F3_BU) || (funct3M == F3_HU);
        st_ok    = (funct3M == F3_B) || (funct3M == F3_H) || (funct3M == F3_W);
        unsup    = (MemReadM & MemWriteM) | (MemReadM & ~ld_ok) | (MemWriteM & ~st_ok);
        misal    = ((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                   ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
        if (unsup) begin
            req_fault = FaultUnsup;
        end else if (misal) begin
            req_fault = FaultMisalign;
        end else begin
            req_fault = FaultNone;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        StallM    = 1'b0;
        fault     = FaultNone;

        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (req_fault != FaultNone) begin
                        fault = req_fault;
                        if (MemReadM) begin
                            rdata_d = '0;
                        end
                    end else begin
                        StallM    = 1'b1;
                        req_d     = 1'b1;
                        we_d      = MemWriteM;
                        addr_d    = {ALUResultM[31:2], 2'b00};
                        be_d      = al_be;
                        wdata_d   = MemWriteM ? al_wdata : '0;
                        f3_d      = funct3M;
                        off_d     = ALUResultM[1:0];
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                StallM = 1'b1;
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = al_ld;
                    end
                    req_d   = 1'b0;
                    state_d = StDone;
                end else if ((BUS_TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    req_d     = 1'b0;
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                fault   = timeout_q ? FaultTimeout : FaultNone;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
        end
    end

    assign ReadDataM = rdata_q;
    assign FaultM    = fault;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus reset, timeout and
// back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic [1:0]  FaultM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.BUS_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  exp_fault;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        set_op(v.rd, v.wr, v.f3, v.addr, v.wdata);
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5A5A5;
        #1;
        if (!v.exp_req) begin
            check({p, " idle_stall"}, StallM, 0);
            check({p, " idle_fault"}, FaultM, v.exp_fault);
            check({p, " idle_req"}, mem_req, 0);
            @(negedge clk);
            set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            #1;
            check({p, " post_req"}, mem_req, 0);
            check({p, " readdata"}, ReadDataM, v.exp_rd);
        end else begin
            check({p, " idle_stall"}, StallM, 1);
            check({p, " idle_fault"}, FaultM, 0);
            @(negedge clk);
            #1;
            check({p, " req"}, mem_req, 1);
            check({p, " req_stall"}, StallM, 1);
            check({p, " we"}, mem_we, v.wr);
            check({p, " addr"}, mem_addr, v.exp_addr);
            if (v.wr) begin
                check({p, " be"}, mem_be, v.exp_be);
                check({p, " wdata"}, mem_wdata, v.exp_wdata);
            end
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'hA5A5A5A5;
            #1;
            check({p, " done_req"}, mem_req, 0);
            check({p, " done_stall"}, StallM, 0);
            check({p, " done_fault"}, FaultM, 0);
            check({p, " readdata"}, ReadDataM, v.exp_rd);
            @(negedge clk);
            set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            #1;
            check({p, " no_reissue"}, mem_req, 0);
            check({p, " idle_after"}, StallM, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqc;
        int wec;
        //             rd    wr    f3      addr          wdata         rdata         flt    req   eaddr         ebe    ewdata        erd
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        2'd0, 1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0,         32'h80FF_1234, 2'd0, 1'b1, 32'h0000_2000, 4'h0, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0,         32'h80FF_1234, 2'd0, 1'b1, 32'h0000_2000, 4'h0, 32'h0,         32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        2'd0, 1'b1, 32'h0000_2000, 4'hC, 32'hABCD_ABCD, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'h0,         32'h0,        2'd1, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 2'd0, 1'b1, 32'h0000_2000, 4'h0, 32'h0,         32'hFFFF_8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 2'd0, 1'b1, 32'h0000_2000, 4'h0, 32'h0,         32'h0000_8001};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3008, 32'h0,         32'h1234_5678, 2'd0, 1'b1, 32'h0000_3008, 4'h0, 32'h0,         32'h1234_5678};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_3005, 32'h0000_00A7, 32'h0,        2'd0, 1'b1, 32'h0000_3004, 4'h2, 32'hA7A7_A7A7, 32'h1234_5678};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,         32'h0,        2'd2, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1111_1111, 32'h0,        2'd1, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0,         32'h0,        2'd2, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_4000, 32'h0,         32'h0000_007F, 2'd0, 1'b1, 32'h0000_4000, 4'h0, 32'h0,         32'h0000_007F};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h0000_4000, 32'h2222_2222, 32'h0,        2'd2, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0000_007F};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0,         32'h0,        2'd1, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0,         32'hCAFE_F00D, 2'd0, 1'b1, 32'h0000_4004, 4'h0, 32'h0,         32'hCAFE_F00D};

        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #12;
        check("rst readdata", ReadDataM, 0);
        check("rst req", mem_req, 0);
        check("rst stall", StallM, 0);
        check("rst fault", FaultM, 0);
        check("rst addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted on the second REQ cycle of a load.
        @(negedge clk);
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
        @(negedge clk);
        #1;
        check("rstmid req1", mem_req, 1);
        @(negedge clk);
        #1;
        check("rstmid req2", mem_req, 1);
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("rstmid req", mem_req, 0);
        check("rstmid addr", mem_addr, 0);
        check("rstmid be", mem_be, 0);
        check("rstmid we", mem_we, 0);
        check("rstmid wdata", mem_wdata, 0);
        check("rstmid readdata", ReadDataM, 0);
        check("rstmid stall", StallM, 0);
        check("rstmid fault", FaultM, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b1, 1'b0, 3'b010, 32'h0000_6010, 32'h0, 32'h0BAD_F00D, 2'd0, 1'b1,
                  32'h0000_6010, 4'h0, 32'h0, 32'h0BAD_F00D}, 100);

        // Bus timeout: mem_ready never arrives.
        @(negedge clk);
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
        mem_ready = 1'b0;
        reqc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (StallM && mem_req) reqc++;
            else break;
        end
        check("tmo req_cycles", reqc, 4);
        check("tmo req", mem_req, 0);
        check("tmo stall", StallM, 0);
        check("tmo fault", FaultM, 2'b11);
        check("tmo readdata", ReadDataM, 0);
        @(negedge clk);
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("tmo fault_clear", FaultM, 0);
        check("tmo idle_req", mem_req, 0);

        // Back-to-back LW then SW with mem_ready held high throughout.
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA_1234;
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        reqc = 0;
        wec  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (mem_req) reqc++;
            if (mem_req && mem_we) wec++;
            if (c == 1) set_op(1'b0, 1'b1, 3'b010, 32'h0000_7004, 32'h0102_0304);
            if (c == 4) set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        end
        mem_ready = 1'b0;
        check("b2b req_cycles", reqc, 2);
        check("b2b we_cycles", wec, 1);
        check("b2b readdata", ReadDataM, 32'h55AA_1234);
        check("b2b addr", mem_addr, 32'h0000_7004);
        check("b2b wdata", mem_wdata, 32'h0102_0304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
